// File: rtl/spe_dwc_sched.sv
// Depthwise-conv SPE sequencer: latches layer config, holds the per-channel
// alpha/beta/sign table, feeds PE products and tracks beats through the SPE.
module spe_dwc_sched #(
    parameter int WORD_SIZE = 16,
    parameter int TILE_NUM  = 2,
    parameter int CH_NUM    = 64,
    parameter int CH_W      = 6,
    parameter int PIX_W     = 12,
    parameter int SPE_LAT   = 8,
    parameter int BN_DLY_BF = 0,
    parameter int BN_DLY_AF = 5
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic                            cfg_isize,
    input  logic                            cfg_wsize,
    input  logic                            cfg_batch_first,
    input  logic                            cfg_have_batch,
    input  logic                            cfg_have_relu,
    input  logic [5:0]                      cfg_quant_pe,
    input  logic [5:0]                      cfg_quant_norm,
    input  logic [CH_W:0]                   cfg_ch_num,
    input  logic [PIX_W-1:0]                cfg_pix_num,
    input  logic                            prm_we,
    input  logic [CH_W-1:0]                 prm_addr,
    input  logic [2*WORD_SIZE+TILE_NUM-1:0] prm_wdata,
    input  logic                            prm_done,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [WORD_SIZE-1:0]            in_data,
    output logic [WORD_SIZE-1:0]            spe_pe_product,
    output logic [WORD_SIZE-1:0]            spe_alpha,
    output logic [WORD_SIZE-1:0]            spe_beta,
    output logic [TILE_NUM-1:0]             spe_alpha_sign,
    output logic                            spe_isize,
    output logic                            spe_wsize,
    output logic                            spe_batch_first,
    output logic                            spe_have_batch,
    output logic                            spe_have_relu,
    output logic [5:0]                      spe_quant_pe,
    output logic [5:0]                      spe_quant_norm,
    output logic                            out_valid,
    output logic [CH_W-1:0]                 out_ch,
    output logic                            busy,
    output logic                            done
);
    localparam int PRM_W = 2*WORD_SIZE + TILE_NUM;
    localparam int DMAX  = (BN_DLY_AF > BN_DLY_BF) ? BN_DLY_AF : BN_DLY_BF;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_DRAIN, S_DONE} state_t;
    state_t state, state_nxt;

    logic [CH_W:0]      ch_num;
    logic [PIX_W-1:0]   pix_num;
    logic [CH_W-1:0]    ch;
    logic [PIX_W-1:0]   pix;
    logic               accept, last_beat;
    logic [PRM_W-1:0]   prm_table [CH_NUM];
    logic [SPE_LAT-1:0] vld_sr;
    logic [CH_W-1:0]    ch_sr [SPE_LAT];
    logic [DMAX-1:0]    dly_vld;
    logic [PRM_W-1:0]   dly_prm [DMAX];
    logic               pipe0_vld, bf_vld, af_vld, sel_vld;
    logic [PRM_W-1:0]   pipe0_prm, bf_prm, af_prm, sel_prm;

    assign accept    = in_valid & in_ready;
    assign last_beat = (pix == pix_num - PIX_W'(1)) && ({1'b0, ch} == ch_num - (CH_W+1)'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_LOAD;
            S_LOAD:  if (prm_done) state_nxt = S_RUN;
            S_RUN:   if (accept && last_beat) state_nxt = S_DRAIN;
            // Leave when only the tail beat remains, so done lands one cycle after it.
            S_DRAIN: if (vld_sr[SPE_LAT-2:0] == '0) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state == S_RUN);
        busy     = (state != S_IDLE);
        done     = (state == S_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            spe_isize       <= 1'b0;
            spe_wsize       <= 1'b0;
            spe_batch_first <= 1'b0;
            spe_have_batch  <= 1'b0;
            spe_have_relu   <= 1'b0;
            spe_quant_pe    <= '0;
            spe_quant_norm  <= '0;
            ch_num          <= '0;
            pix_num         <= '0;
        end else if (state == S_IDLE && start) begin
            spe_isize       <= cfg_isize;
            spe_wsize       <= cfg_wsize;
            spe_batch_first <= cfg_batch_first;
            spe_have_batch  <= cfg_have_batch;
            spe_have_relu   <= cfg_have_relu;
            spe_quant_pe    <= cfg_quant_pe;
            spe_quant_norm  <= cfg_quant_norm;
            ch_num          <= cfg_ch_num;
            pix_num         <= cfg_pix_num;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ch  <= '0;
            pix <= '0;
        end else if (state == S_IDLE && start) begin
            ch  <= '0;
            pix <= '0;
        end else if (accept) begin
            if (pix == pix_num - PIX_W'(1)) begin
                pix <= '0;
                ch  <= ch + CH_W'(1);
            end else begin
                pix <= pix + PIX_W'(1);
            end
        end
    end

    // Table contents survive reset so a layer can rerun without reloading.
    always_ff @(posedge clk) begin
        if (prm_we && state == S_LOAD) prm_table[prm_addr] <= prm_wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_sr <= '0;
            for (int i = 0; i < SPE_LAT; i++) ch_sr[i] <= '0;
        end else begin
            vld_sr[0] <= accept;
            ch_sr[0]  <= ch;
            for (int i = 1; i < SPE_LAT; i++) begin
                vld_sr[i] <= vld_sr[i-1];
                ch_sr[i]  <= ch_sr[i-1];
            end
        end
    end

    assign out_valid = vld_sr[SPE_LAT-1];
    assign out_ch    = ch_sr[SPE_LAT-1];

    // Params travel with each beat; stage k of the pipe is k+1 cycles behind accept.
    assign pipe0_vld = accept;
    assign pipe0_prm = prm_table[ch];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dly_vld <= '0;
            for (int i = 0; i < DMAX; i++) dly_prm[i] <= '0;
        end else begin
            dly_vld[0] <= pipe0_vld;
            dly_prm[0] <= pipe0_prm;
            for (int i = 1; i < DMAX; i++) begin
                dly_vld[i] <= dly_vld[i-1];
                dly_prm[i] <= dly_prm[i-1];
            end
        end
    end

    if (BN_DLY_BF == 0) begin : g_bf_now
        assign bf_vld = pipe0_vld;
        assign bf_prm = pipe0_prm;
    end else begin : g_bf_dly
        assign bf_vld = dly_vld[BN_DLY_BF-1];
        assign bf_prm = dly_prm[BN_DLY_BF-1];
    end

    if (BN_DLY_AF == 0) begin : g_af_now
        assign af_vld = pipe0_vld;
        assign af_prm = pipe0_prm;
    end else begin : g_af_dly
        assign af_vld = dly_vld[BN_DLY_AF-1];
        assign af_prm = dly_prm[BN_DLY_AF-1];
    end

    assign sel_vld = spe_batch_first ? bf_vld : af_vld;
    assign sel_prm = spe_batch_first ? bf_prm : af_prm;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            spe_pe_product <= '0;
            spe_alpha      <= '0;
            spe_beta       <= '0;
            spe_alpha_sign <= '0;
        end else begin
            if (accept) spe_pe_product <= in_data;
            if (sel_vld) {spe_alpha_sign, spe_beta, spe_alpha} <= sel_prm;
        end
    end
endmodule
